// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multicycle MIPS control path.
// Holds opcode values, FSM state encodings, ALU operation codes, datapath
// mux select codes and fault codes, plus a helper that identifies the
// states that wait on the memory.
package mips_pkg;

    // Instruction opcodes, instruction register bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation requests to the ALU decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    typedef enum logic [1:0] {
        FaultNone    = 2'b00,
        FaultIllegal = 2'b01,
        FaultTimeout = 2'b10
    } fault_e;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StFault  = 4'd15
    } state_e;

    // States that hold a memory access open until mem_ready
    function automatic logic is_mem_state(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: 8-bit memory wait counter with limit detection.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, clears the count
//   clear   - zero the count next cycle (wins over enable)
//   enable  - a waiting cycle: increment the count
//   limit   - number of waiting cycles allowed
//   expired - this waiting cycle is the one that reaches the limit
module mc_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    // 9-bit compare so a count of 255 cannot wrap into a false match; a limit of
    // zero therefore never expires.
    always_comb begin
        expired = enable && (({1'b0, count_q} + 9'd1) == {1'b0, limit});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle MIPS control FSM.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   opcode            - instruction register bits [31:26]
//   mem_ready         - memory finished the current read/write this cycle
//   pc_write_cond ... reg_dst - datapath control strobes
//   pc_source, alu_op, alu_src_b - datapath mux selects
//   state             - current state encoding (debug)
//   fault             - 00 none, 01 illegal opcode, 10 memory timeout
//   retire            - pulses on the last cycle of each completed instruction
module mc_sequencer
    import mips_pkg::*;
#(
    parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write_cond,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [3:0] state,
    output logic [1:0] fault,
    output logic       retire
);

    state_e state_q, state_d;
    fault_e fault_q, fault_d;
    logic   timer_clear, timer_enable, timer_expired;

    // Only memory states count, and only while the memory is stalling.
    assign timer_enable = is_mem_state(state_q) && !mem_ready;
    // Any state change restarts the count, covering every entry into a memory state.
    assign timer_clear  = mem_ready || (state_d != state_q);

    mc_wait_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (WAIT_LIMIT),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        pc_write_cond = 1'b0;
        pc_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_b     = SRCB_REG;
        retire        = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timer_expired) begin
                    state_d = StFault;
                    fault_d = FaultTimeout;
                end
            end
            StDecode: begin
                alu_src_b = SRCB_IMM_SH;
                unique case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiEx;
                    default: begin
                        state_d = StFault;
                        fault_d = FaultIllegal;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_LW) begin
                    state_d = StMemRd;
                end else if (opcode == OP_SW) begin
                    state_d = StMemWr;
                end else begin
                    // Opcode changed under us; treat as illegal rather than guess.
                    state_d = StFault;
                    fault_d = FaultIllegal;
                end
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timer_expired) begin
                    state_d = StFault;
                    fault_d = FaultTimeout;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (timer_expired) begin
                    state_d = StFault;
                    fault_d = FaultTimeout;
                end
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = StRwb;
            end
            StRwb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                // Unused encodings can only come from an upset; park in FAULT.
                state_d = StFault;
            end
        endcase

        // Reset is synchronous, so the old state is still visible during reset;
        // suppress anything that would commit architectural state.
        if (rst) begin
            pc_write_cond = 1'b0;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            retire        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            fault_q <= FaultNone;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule
